spi_cfg_master: RTL and testbench

SPI mode-0 master that drives the accelerator's configuration SPI slave port (SCLK, MOSI, SS, MISO) from a simple parallel start/done request interface. It serialises one DATA_W-bit word per transaction MSB-first on MOSI and captures the slave's MISO response into a parallel word. It is the host-side end of the link, used in the bring-up/host wrapper and as the reusable driver in the top-level verification environment.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_cfg_master_clk_gen.sv | 52 +++++
 rtl/spi_cfg_master.sv | 153 +++++++++++++++
 tb/tb_spi_cfg_master.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the configuration SPI link: master FSM states and the
// clock polarity/phase both ends of the link agree on.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_t;

    localparam int SPI_CPOL = 0;
    localparam int SPI_CPHA = 0;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/spi_cfg_master_clk_gen.sv
// SCLK timing for the SHIFT phase: half-period counter, phase tracking and
// bit counter. Everything is held cleared while the block is disabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic last_bit,
    output logic finish
);

    localparam int HW = cnt_width(CLK_DIV);
    localparam int BW = cnt_width(DATA_W);

    logic [HW-1:0] half_reg;
    logic [BW-1:0] bit_reg;
    logic          high_reg;
    logic          tc;
    logic          all_bits;

    assign tc       = en && (half_reg == HW'(CLK_DIV - 1));
    assign all_bits = (bit_reg == BW'(DATA_W));
    assign rise     = tc && !high_reg && !all_bits;
    assign fall     = tc && high_reg;
    assign last_bit = (bit_reg == BW'(DATA_W - 1));
    // The low half-period after the final falling edge still belongs to SHIFT.
    assign finish   = tc && !high_reg && all_bits;

    // SHIFT is entered with SCLK already driven high, so the phase idles "high".
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            half_reg <= '0;
            bit_reg  <= '0;
            high_reg <= 1'b1;
        end else if (tc) begin
            half_reg <= '0;
            high_reg <= ~high_reg;
            if (high_reg) begin
                bit_reg <= bit_reg + BW'(1);
            end
        end else begin
            half_reg <= half_reg + HW'(1);
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 master for the accelerator configuration port: one DATA_W-bit
// full-duplex word per start/done handshake, MSB first.
module spi_cfg_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    output logic              SS,
    input  logic              MISO
);

    localparam int   CW        = cnt_width(CLK_DIV);
    localparam logic SCLK_IDLE = (SPI_CPOL != 0);

    spi_state_t        state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DATA_W-1:0] tx_sr_reg;
    logic [DATA_W-1:0] rx_sr_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic              ss_reg;
    logic              busy_reg;
    logic              done_reg;

    logic cnt_tc;
    logic cg_en;
    logic cg_rise;
    logic cg_fall;
    logic cg_last_bit;
    logic cg_finish;
    logic lead_evt;
    logic cap_evt;

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (cg_en),
        .rise    (cg_rise),
        .fall    (cg_fall),
        .last_bit(cg_last_bit),
        .finish  (cg_finish)
    );

    assign cg_en    = (state_reg == SHIFT);
    assign cnt_tc   = (cnt_reg == CW'(CLK_DIV - 1));
    // The first leading edge is issued by LEAD itself; later ones by the clock generator.
    assign lead_evt = ((state_reg == LEAD) && cnt_tc) || cg_rise;
    assign cap_evt  = (SPI_CPHA == 0) ? lead_evt : cg_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            tx_sr_reg   <= '0;
            rx_sr_reg   <= '0;
            rx_data_reg <= '0;
            sclk_reg    <= SCLK_IDLE;
            mosi_reg    <= 1'b0;
            ss_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tx_sr_reg <= tx_data;
                        mosi_reg  <= tx_data[DATA_W-1];
                        ss_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= LEAD;
                    end
                end
                LEAD: begin
                    if (cnt_tc) begin
                        cnt_reg   <= '0;
                        sclk_reg  <= ~SCLK_IDLE;
                        state_reg <= SHIFT;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cg_rise) begin
                        sclk_reg <= ~SCLK_IDLE;
                    end
                    if (cg_fall) begin
                        sclk_reg <= SCLK_IDLE;
                        // MOSI keeps the final bit through the trailing low half-period.
                        if (!cg_last_bit) begin
                            tx_sr_reg <= tx_sr_reg << 1;
                            mosi_reg  <= tx_sr_reg[DATA_W-2];
                        end
                    end
                    if (cg_finish) begin
                        cnt_reg   <= '0;
                        state_reg <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (cnt_tc) begin
                        cnt_reg   <= '0;
                        ss_reg    <= 1'b1;
                        mosi_reg  <= 1'b0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_tc) begin
                        cnt_reg     <= '0;
                        rx_data_reg <= rx_sr_reg;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            if (cap_evt) begin
                rx_sr_reg <= {rx_sr_reg[DATA_W-2:0], MISO};
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = mosi_reg;
    assign SS      = ss_reg;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: three instances (16b/div4, 16b/div1, 2b/div1), each
// with an event-driven mode-0 slave, checked against timing derived from the bit rules.
module tb_spi_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_w     [3];
    logic        start_w   [3];
    logic        busy_w    [3];
    logic        done_w    [3];
    logic        sclk_w    [3];
    logic        mosi_w    [3];
    logic        ss_w      [3];
    logic        miso_w    [3];
    logic [15:0] tx_w      [3];
    logic [15:0] rx16      [3];
    logic [15:0] slv_resp  [3];
    logic [15:0] last_cap  [3];
    int          cap_count [3];
    int          done_count[3];

    int checks   = 0;
    int failures = 0;

    function automatic int dw_of(input int k);
        return (k == 2) ? 2 : 16;
    endfunction

    function automatic int cd_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Lead + 2 half-periods per bit + trail + gap, plus the accept edge.
    function automatic int exp_latency(input int k);
        return (3 + 2 * dw_of(k)) * cd_of(k) + 1;
    endfunction

    function automatic logic [15:0] word_mask(input int k);
        logic [31:0] m;
        m = (32'd1 << dw_of(k)) - 32'd1;
        return m[15:0];
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int DW = (gi == 2) ? 2 : 16;
        localparam int CD = (gi == 0) ? 4 : 1;

        logic [DW-1:0] rx_loc;
        logic          s_ss_q   = 1'b1;
        logic          s_sclk_q = 1'b0;
        int            s_idx;
        int            s_rises;
        logic [15:0]   s_cap;

        spi_cfg_master #(
            .DATA_W (DW),
            .CLK_DIV(CD)
        ) u_dut (
            .clk    (clk),
            .rst    (rst_w[gi]),
            .start  (start_w[gi]),
            .tx_data(tx_w[gi][DW-1:0]),
            .busy   (busy_w[gi]),
            .done   (done_w[gi]),
            .rx_data(rx_loc),
            .SCLK   (sclk_w[gi]),
            .MOSI   (mosi_w[gi]),
            .SS     (ss_w[gi]),
            .MISO   (miso_w[gi])
        );

        assign rx16[gi] = 16'(rx_loc);

        // Mode-0 slave: first bit on SS fall, next bit on each SCLK fall, capture on SCLK rise.
        always @(ss_w[gi] or sclk_w[gi]) begin
            if (ss_w[gi] !== s_ss_q) begin
                if (ss_w[gi] == 1'b0) begin
                    s_idx      = 0;
                    s_rises    = 0;
                    s_cap      = '0;
                    miso_w[gi] = slv_resp[gi][DW-1];
                end else if (s_rises == DW) begin
                    last_cap[gi]  = s_cap;
                    cap_count[gi] = cap_count[gi] + 1;
                end
                s_ss_q = ss_w[gi];
            end
            if (sclk_w[gi] !== s_sclk_q) begin
                if (ss_w[gi] == 1'b0) begin
                    if (sclk_w[gi] == 1'b1) begin
                        s_cap   = {s_cap[14:0], mosi_w[gi]};
                        s_rises = s_rises + 1;
                    end else begin
                        s_idx = s_idx + 1;
                        if (s_idx < DW) miso_w[gi] = slv_resp[gi][DW-1-s_idx];
                    end
                end
                s_sclk_q = sclk_w[gi];
            end
        end

        always @(posedge clk) begin
            if (done_w[gi] === 1'b1) done_count[gi] = done_count[gi] + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a transfer on instance k and measures it until done (or a cycle budget).
    task automatic run_xfer(input int k, input logic [15:0] tx, input logic [15:0] resp,
                            output int lat, output int rises, output int ss_low,
                            output int min_per, output int max_per, output int hi_cyc);
        logic prev_sclk;
        int   last_rise;
        slv_resp[k] = resp;
        tx_w[k]     = tx;
        start_w[k]  = 1'b1;
        step();
        start_w[k]  = 1'b0;
        tx_w[k]     = 16'($urandom);
        lat = -1; rises = 0; ss_low = 0; hi_cyc = 0;
        min_per = 1000000; max_per = -1;
        prev_sclk = 1'b0; last_rise = -1;
        for (int n = 1; n < 3000; n++) begin
            if (ss_w[k] == 1'b0) ss_low++;
            if (sclk_w[k] == 1'b1) hi_cyc++;
            if (sclk_w[k] == 1'b1 && prev_sclk == 1'b0) begin
                rises++;
                if (last_rise >= 0) begin
                    if (n - last_rise < min_per) min_per = n - last_rise;
                    if (n - last_rise > max_per) max_per = n - last_rise;
                end
                last_rise = n;
            end
            prev_sclk = sclk_w[k];
            if (done_w[k] == 1'b1) begin
                lat = n;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            checks++; if (ss_w[k] !== 1'b1) begin failures++; $display("FAIL reset_ss[%0d]: got %b expected 1", k, ss_w[k]); end
            checks++; if (sclk_w[k] !== 1'b0) begin failures++; $display("FAIL reset_sclk[%0d]: got %b expected 0", k, sclk_w[k]); end
            checks++; if (mosi_w[k] !== 1'b0) begin failures++; $display("FAIL reset_mosi[%0d]: got %b expected 0", k, mosi_w[k]); end
            checks++; if (busy_w[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_w[k]); end
            checks++; if (done_w[k] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_w[k]); end
            checks++; if (rx16[k] !== 16'h0) begin failures++; $display("FAIL reset_rx[%0d]: got %h expected 0000", k, rx16[k]); end
        end
        for (int k = 0; k < 3; k++) rst_w[k] = 1'b1;
        step();
        $display("reset: all instances checked");
    endtask

    task automatic test_single();
        int lat, rises, ss_low, pmin, pmax, hi;
        run_xfer(0, 16'hA5C3, 16'h3C5A, lat, rises, ss_low, pmin, pmax, hi);
        checks++; if (lat !== exp_latency(0)) begin failures++; $display("FAIL single_latency: got %0d expected %0d", lat, exp_latency(0)); end
        checks++; if (rx16[0] !== 16'h3C5A) begin failures++; $display("FAIL single_rx: got %h expected 3c5a", rx16[0]); end
        checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL single_busy_at_done: got %b expected 0", busy_w[0]); end
        checks++; if (last_cap[0] !== 16'hA5C3) begin failures++; $display("FAIL single_slave_cap: got %h expected a5c3", last_cap[0]); end
        checks++; if (rises !== 16) begin failures++; $display("FAIL single_rises: got %0d expected 16", rises); end
        checks++; if (ss_low !== (2 * 16 + 2) * 4) begin failures++; $display("FAIL single_ss_low: got %0d expected %0d", ss_low, (2 * 16 + 2) * 4); end
        checks++; if (pmin !== 8 || pmax !== 8) begin failures++; $display("FAIL single_period: got %0d..%0d expected 8", pmin, pmax); end
        checks++; if (hi !== 16 * 4) begin failures++; $display("FAIL single_sclk_high: got %0d expected %0d", hi, 16 * 4); end
        step();
        checks++; if (done_w[0] !== 1'b0) begin failures++; $display("FAIL single_done_width: got %b expected 0", done_w[0]); end
        checks++; if (rx16[0] !== 16'h3C5A) begin failures++; $display("FAIL single_rx_hold: got %h expected 3c5a", rx16[0]); end
        $display("single: tx=a5c3 rx=%h latency=%0d rises=%0d", rx16[0], lat, rises);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int          k;
            int          lat, rises, ss_low, pmin, pmax, hi;
            logic [15:0] tx, resp;
            k    = i % 3;
            tx   = 16'($urandom) & word_mask(k);
            resp = 16'($urandom) & word_mask(k);
            run_xfer(k, tx, resp, lat, rises, ss_low, pmin, pmax, hi);
            checks++; if (lat !== exp_latency(k)) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(k)); end
            checks++; if (rx16[k] !== resp) begin failures++; $display("FAIL rand_rx[%0d]: got %h expected %h", i, rx16[k], resp); end
            checks++; if (last_cap[k] !== tx) begin failures++; $display("FAIL rand_slave_cap[%0d]: got %h expected %h", i, last_cap[k], tx); end
            checks++; if (rises !== dw_of(k)) begin failures++; $display("FAIL rand_rises[%0d]: got %0d expected %0d", i, rises, dw_of(k)); end
            step();
            $display("random[%0d]: inst=%0d tx=%h resp=%h rx=%h", i, k, tx, resp, rx16[k]);
        end
    endtask

    task automatic test_back_to_back();
        int   n, t1, t2, run, ss_high_run, c0;
        logic prev_ss;
        bit   counting;
        c0          = cap_count[1];
        slv_resp[1] = 16'hC3C3;
        tx_w[1]     = 16'h0001;
        start_w[1]  = 1'b1;
        step();
        tx_w[1] = 16'h8000;
        t1 = -1; t2 = -1; run = 0; ss_high_run = -1; counting = 1'b0;
        prev_ss = ss_w[1];
        n = 1;
        while (n < 400) begin
            if (prev_ss == 1'b0 && ss_w[1] == 1'b1) begin counting = 1'b1; run = 0; end
            if (counting && ss_w[1] == 1'b1) run++;
            if (counting && prev_ss == 1'b1 && ss_w[1] == 1'b0) begin ss_high_run = run; counting = 1'b0; end
            prev_ss = ss_w[1];
            if (done_w[1] == 1'b1) begin
                if (t1 < 0) begin
                    t1 = n;
                    checks++; if (busy_w[1] !== 1'b0) begin failures++; $display("FAIL b2b_busy_at_done: got %b expected 0", busy_w[1]); end
                    checks++; if (rx16[1] !== 16'hC3C3) begin failures++; $display("FAIL b2b_rx1: got %h expected c3c3", rx16[1]); end
                    checks++; if (last_cap[1] !== 16'h0001) begin failures++; $display("FAIL b2b_cap1: got %h expected 0001", last_cap[1]); end
                    slv_resp[1] = 16'h5A5A;
                end else begin
                    t2 = n;
                    break;
                end
            end
            if (t1 > 0 && n == t1 + 1) begin
                checks++; if (busy_w[1] !== 1'b1) begin failures++; $display("FAIL b2b_accept_in_done: busy got %b expected 1", busy_w[1]); end
                start_w[1] = 1'b0;
            end
            step();
            n++;
        end
        start_w[1] = 1'b0;
        checks++; if (t1 !== exp_latency(1)) begin failures++; $display("FAIL b2b_latency1: got %0d expected %0d", t1, exp_latency(1)); end
        checks++; if (t2 - t1 !== exp_latency(1)) begin failures++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, exp_latency(1)); end
        checks++; if (ss_high_run !== cd_of(1) + 1) begin failures++; $display("FAIL b2b_ss_high: got %0d expected %0d", ss_high_run, cd_of(1) + 1); end
        checks++; if (rx16[1] !== 16'h5A5A) begin failures++; $display("FAIL b2b_rx2: got %h expected 5a5a", rx16[1]); end
        checks++; if (last_cap[1] !== 16'h8000) begin failures++; $display("FAIL b2b_cap2: got %h expected 8000", last_cap[1]); end
        checks++; if (cap_count[1] - c0 !== 2) begin failures++; $display("FAIL b2b_cap_count: got %0d expected 2", cap_count[1] - c0); end
        step();
        $display("back_to_back: done at %0d and %0d, ss high %0d cycles", t1, t2, ss_high_run);
    endtask

    task automatic test_busy_reject();
        int d0, c0, got;
        d0 = done_count[0];
        c0 = cap_count[0];
        slv_resp[0] = 16'hBEEF;
        tx_w[0]     = 16'h1234;
        start_w[0]  = 1'b1;
        step();
        start_w[0] = 1'b0;
        repeat (9) step();
        tx_w[0]    = 16'hFFFF;
        start_w[0] = 1'b1;
        step();
        start_w[0] = 1'b0;
        got = 0;
        for (int n = 0; n < 400; n++) begin
            if (done_w[0] == 1'b1) begin got = 1; break; end
            step();
        end
        repeat (300) step();
        checks++; if (got !== 1) begin failures++; $display("FAIL busy_done_seen: got %0d expected 1", got); end
        checks++; if (done_count[0] - d0 !== 1) begin failures++; $display("FAIL busy_done_count: got %0d expected 1", done_count[0] - d0); end
        checks++; if (cap_count[0] - c0 !== 1) begin failures++; $display("FAIL busy_slave_words: got %0d expected 1", cap_count[0] - c0); end
        checks++; if (last_cap[0] !== 16'h1234) begin failures++; $display("FAIL busy_slave_cap: got %h expected 1234", last_cap[0]); end
        checks++; if (rx16[0] !== 16'hBEEF) begin failures++; $display("FAIL busy_rx: got %h expected beef", rx16[0]); end
        $display("busy_reject: dones=%0d slave=%h", done_count[0] - d0, last_cap[0]);
    endtask

    task automatic test_mid_reset();
        int   rises, d0, lat, r2, ss_low, pmin, pmax, hi;
        logic prev_sclk;
        slv_resp[0] = 16'h1111;
        tx_w[0]     = 16'hC0DE;
        start_w[0]  = 1'b1;
        step();
        start_w[0] = 1'b0;
        rises = 0;
        prev_sclk = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (sclk_w[0] == 1'b1 && prev_sclk == 1'b0) rises++;
            prev_sclk = sclk_w[0];
            if (rises == 5) break;
            step();
        end
        checks++; if (rises !== 5) begin failures++; $display("FAIL midrst_reach_rise5: got %0d expected 5", rises); end
        d0 = done_count[0];
        rst_w[0] = 1'b0;
        step();
        checks++; if (ss_w[0] !== 1'b1) begin failures++; $display("FAIL midrst_ss: got %b expected 1", ss_w[0]); end
        checks++; if (sclk_w[0] !== 1'b0) begin failures++; $display("FAIL midrst_sclk: got %b expected 0", sclk_w[0]); end
        checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy_w[0]); end
        checks++; if (rx16[0] !== 16'h0) begin failures++; $display("FAIL midrst_rx: got %h expected 0000", rx16[0]); end
        rst_w[0] = 1'b1;
        repeat (300) step();
        checks++; if (done_count[0] !== d0) begin failures++; $display("FAIL midrst_no_done: got %0d extra expected 0", done_count[0] - d0); end
        run_xfer(0, 16'h00FF, 16'h5A5A, lat, r2, ss_low, pmin, pmax, hi);
        checks++; if (lat !== exp_latency(0)) begin failures++; $display("FAIL midrst_after_latency: got %0d expected %0d", lat, exp_latency(0)); end
        checks++; if (rx16[0] !== 16'h5A5A) begin failures++; $display("FAIL midrst_after_rx: got %h expected 5a5a", rx16[0]); end
        checks++; if (last_cap[0] !== 16'h00FF) begin failures++; $display("FAIL midrst_after_cap: got %h expected 00ff", last_cap[0]); end
        step();
        $display("mid_reset: aborted after %0d rises, follow-up rx=%h", rises, rx16[0]);
    endtask

    task automatic test_boundary();
        int lat, rises, ss_low, pmin, pmax, hi;
        run_xfer(2, 16'h0002, 16'h0001, lat, rises, ss_low, pmin, pmax, hi);
        checks++; if (lat !== 8) begin failures++; $display("FAIL bound_latency: got %0d expected 8", lat); end
        checks++; if (rx16[2] !== 16'h0001) begin failures++; $display("FAIL bound_rx: got %h expected 0001", rx16[2]); end
        checks++; if (last_cap[2] !== 16'h0002) begin failures++; $display("FAIL bound_cap: got %h expected 0002", last_cap[2]); end
        checks++; if (rises !== 2) begin failures++; $display("FAIL bound_rises: got %0d expected 2", rises); end
        checks++; if (pmin !== 2 || pmax !== 2) begin failures++; $display("FAIL bound_period: got %0d..%0d expected 2", pmin, pmax); end
        checks++; if (ss_low !== 6) begin failures++; $display("FAIL bound_ss_low: got %0d expected 6", ss_low); end
        step();
        $display("boundary: tx=10 rx=%b latency=%0d", rx16[2][1:0], lat);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_w[k]      = 1'b0;
            start_w[k]    = 1'b0;
            tx_w[k]       = '0;
            slv_resp[k]   = '0;
            last_cap[k]   = '0;
            cap_count[k]  = 0;
            done_count[k] = 0;
            miso_w[k]     = 1'b0;
        end
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_busy_reject();
        test_mid_reset();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
